// File: rtl/register_file_pkg.sv
// Shared constants for the MIPS register file and its consumers.
package register_file_pkg;

    localparam int unsigned REG_WIDTH  = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_AT   = 5'd1;
    localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/register_file_zero.sv
// Constant-zero source; drives the read path of architectural register $0.
module Zero #(
    parameter int unsigned WIDTH = 32
) (
    output logic [WIDTH-1:0] zero_o
);

    assign zero_o = '0;

endmodule

// File: rtl/register_file.sv
// 32 x 32 MIPS register file: two combinational read ports, one synchronous
// write port, optional write-to-read bypass. $0 has no storage and reads
// through a Zero instance.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned WIDTH  = REG_WIDTH,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata1,
    output logic [WIDTH-1:0]  rdata2
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // Storage exists for indices 1..DEPTH-1 only.
    logic [WIDTH-1:0] regs_q [1:DEPTH-1];
    logic [WIDTH-1:0] zero_w;
    logic [WIDTH-1:0] stored1_w;
    logic [WIDTH-1:0] stored2_w;

    Zero #(.WIDTH(WIDTH)) u_zero (
        .zero_o (zero_w)
    );

    // Shared per-port read selection: $0 constant, else bypass, else storage.
    function automatic logic [WIDTH-1:0] read_sel(
        input logic [ADDR_W-1:0] ra,
        input logic [WIDTH-1:0]  stored,
        input logic              rst,
        input logic              wen,
        input logic [ADDR_W-1:0] wa,
        input logic [WIDTH-1:0]  wd,
        input logic [WIDTH-1:0]  zv
    );
        logic [WIDTH-1:0] r;
        r = stored;
        if (rst) begin
            r = '0;
        end else if (ra == '0) begin
            r = zv;
        end else if (BYPASS && wen && (wa == ra)) begin
            r = wd;
        end
        return r;
    endfunction

    // Storage: async clear, write on rising edge unless targeting $0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Raw storage lookup per port; address 0 is masked off by read_sel.
    always_comb begin
        stored1_w = '0;
        stored2_w = '0;
        if (raddr1 != '0) stored1_w = regs_q[raddr1];
        if (raddr2 != '0) stored2_w = regs_q[raddr2];
    end

    // Port 1 (rs) read mux.
    always_comb begin
        rdata1 = read_sel(raddr1, stored1_w, reset, we, waddr, wdata, zero_w);
    end

    // Port 2 (rt) read mux.
    always_comb begin
        rdata2 = read_sel(raddr2, stored2_w, reset, we, waddr, wdata, zero_w);
    end

endmodule

// File: tb/tb_register_file.sv
// Randomized + directed bench for register_file, checking a BYPASS=1 and a
// BYPASS=0 instance against an array-based reference model.
module tb_register_file;
    import register_file_pkg::*;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

    int unsigned n_checks;
    int unsigned n_fails;

    logic [31:0] model [32];

    register_file #(.WIDTH(32), .ADDR_W(5), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_b), .rdata2(rd2_b)
    );

    register_file #(.WIDTH(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nob (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_n), .rdata2(rd2_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Architectural expectation for a read in the current cycle.
    function automatic logic [31:0] expect_rd(input logic [4:0] a, input bit byp);
        if (reset) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (byp && we && waddr == a) return wdata;
        return model[a];
    endfunction

    task automatic check_all(input string tag);
        #1;
        check({tag, "/byp/p1"}, rd1_b, expect_rd(raddr1, 1'b1));
        check({tag, "/byp/p2"}, rd2_b, expect_rd(raddr2, 1'b1));
        check({tag, "/nob/p1"}, rd1_n, expect_rd(raddr1, 1'b0));
        check({tag, "/nob/p2"}, rd2_n, expect_rd(raddr2, 1'b0));
    endtask

    // Advance one rising edge, updating the model with what the edge commits.
    task automatic tick();
        @(posedge clk);
        if (!reset && we && waddr != 5'd0) model[waddr] = wdata;
        #1;
    endtask

    task automatic set_reset(input logic v);
        reset = v;
        if (v) for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'hx;
        reset = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
        #1;

        // 1: reset clears everything
        set_reset(1'b1);
        tick();
        check_all("in_reset");
        set_reset(1'b0);
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(31 - a);
            check_all("post_reset");
        end

        // 2: simple write
        we = 1'b1; waddr = 5'd8; wdata = 32'hDEADBEEF;
        tick();
        we = 1'b0; raddr1 = 5'd8; raddr2 = 5'd9;
        check_all("wr8");
        check("wr8_literal", rd1_b, 32'hDEADBEEF);

        // 3: write to $0 discarded
        we = 1'b1; waddr = REG_ZERO; wdata = 32'hFFFFFFFF; raddr1 = 5'd0; raddr2 = 5'd0;
        check_all("wr0_pre");
        tick();
        we = 1'b0;
        check_all("wr0_post");

        // 4: bypass vs no bypass before the edge
        we = 1'b1; waddr = 5'd5; wdata = 32'h1234; raddr1 = 5'd5; raddr2 = 5'd5;
        check_all("bypass_pre");
        check("bypass_literal", rd1_b, 32'h1234);
        tick();
        we = 1'b0;
        check_all("bypass_post");

        // 5: async reset without clock, pending write lost
        we = 1'b1; waddr = REG_RA; wdata = 32'hA5A5A5A5;
        tick();
        we = 1'b0; raddr1 = REG_RA; raddr2 = REG_SP;
        check_all("wr31");
        @(negedge clk);
        set_reset(1'b1);
        we = 1'b1; waddr = REG_RA; wdata = 32'h5A5A5A5A;
        check_all("async_reset");
        tick();
        check_all("reset_hold_we");
        set_reset(1'b0);
        we = 1'b0;
        check_all("after_release");
        check("r31_cleared", rd1_n, 32'h0);

        // first write after release lands on the first edge
        we = 1'b1; waddr = REG_AT; wdata = 32'h0BADF00D; raddr1 = REG_AT;
        tick();
        we = 1'b0;
        check_all("first_after_reset");

        // 6: sweep
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'(i * 4);
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(i);
            check_all("sweep");
            if (i != 0) check("sweep_literal", rd2_n, 32'(i * 4));
        end

        // randomized traffic, rare resets
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0) set_reset(1'b1);
            else set_reset(1'b0);
            we     = 1'($urandom_range(0, 1));
            waddr  = 5'($urandom_range(0, 31));
            wdata  = $urandom;
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            check_all("random");
            tick();
        end

        if (n_fails == 0) $display("All tests passed.");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
